// File: rtl/axis_gmii_rx_chk.sv
// GMII receive checker: strips preamble, SFD and FCS, streams the payload
// on AXI-Stream and flags FCS, runt, oversize and PHY errors with counters.
module axis_gmii_rx_chk #(
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int PRE_CHECK = 1,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           gmii_rxd,
  input  logic                 gmii_rx_dv,
  input  logic                 gmii_rx_er,
  input  logic                 clk_enable,
  input  logic                 stat_clear,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 frame_len_valid,
  output logic                 start_packet,
  output logic                 error_bad_frame,
  output logic                 error_bad_fcs,
  output logic                 error_runt,
  output logic                 error_oversize,
  output logic [CNT_WIDTH-1:0] stat_good,
  output logic [CNT_WIDTH-1:0] stat_bad,
  output logic [CNT_WIDTH-1:0] stat_fcs,
  output logic [CNT_WIDTH-1:0] stat_runt,
  output logic [CNT_WIDTH-1:0] stat_oversize
);

  localparam int CW = $clog2(MAX_LEN + 2);
  localparam logic [63:0] LEN_SAT = (64'd1 << LEN_WIDTH) - 64'd1;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    WAIT_LAST
  } state_t;

  state_t               state;
  logic [5:0][7:0]      rxd_d;
  logic [4:0]           dv_d;
  logic [4:0]           er_d;
  logic [31:0]          crc;
  logic [31:0]          crc_next;
  logic [CW-1:0]        len;
  logic                 sfd_hit;
  logic                 fcs_ok;
  logic                 er_any;
  logic                 in_pay;
  logic                 short_frm;
  logic                 runt_len;
  logic                 end_er;
  logic                 end_norm;
  logic                 end_over;
  logic                 is_start;
  logic                 is_bad;
  logic                 is_good;
  logic                 is_runt;
  logic                 is_fcs;
  logic [31:0]          len_val;
  logic [LEN_WIDTH-1:0] len_sat;

  // reflected CRC-32 (0xEDB88320), one byte, LSB first
  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 en
  );
    return (en && c != '1) ? c + CNT_WIDTH'(1) : c;
  endfunction

  // input delay line; dv is killed along the chain when the live dv drops
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_d <= '0;
      dv_d  <= '0;
      er_d  <= '0;
    end else if (clk_enable) begin
      rxd_d <= {rxd_d[4:0], gmii_rxd};
      dv_d  <= {dv_d[3:0] & {4{gmii_rx_dv}}, gmii_rx_dv};
      er_d  <= {er_d[3:0], gmii_rx_er};
    end
  end

  // frame start / end decisions and error classification
  always_comb begin
    crc_next  = crc_step(crc, rxd_d[4]);
    fcs_ok    = {rxd_d[0], rxd_d[1], rxd_d[2], rxd_d[3]} == ~crc_next;
    er_any    = |er_d[3:0];
    sfd_hit   = dv_d[4] && !er_d[4] && rxd_d[4] == 8'hD5 &&
                (PRE_CHECK == 0 || rxd_d[5] == 8'h55);
    in_pay    = clk_enable && state == PAYLOAD;
    is_start  = clk_enable && state == IDLE && sfd_hit;
    short_frm = len <= CW'(5);
    runt_len  = len < CW'(MIN_LEN);
    end_er    = in_pay && dv_d[4] && er_d[4];
    end_norm  = in_pay && !end_er && !gmii_rx_dv;
    end_over  = in_pay && !end_er && gmii_rx_dv &&
                len == CW'(MAX_LEN);
    is_runt   = end_norm && !er_any && runt_len;
    is_fcs    = end_norm && !er_any && !short_frm && !fcs_ok;
    is_bad    = end_er || end_over ||
                (end_norm &&
                 (er_any || short_frm || runt_len || !fcs_ok));
    is_good   = end_norm && !is_bad;
    len_val   = end_over ? 32'(MAX_LEN + 1) : 32'(len);
    len_sat   = ({32'd0, len_val} > LEN_SAT) ?
                LEN_WIDTH'(LEN_SAT) : LEN_WIDTH'(len_val);
  end

  // receive FSM with registered stream and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      crc             <= '1;
      len             <= '0;
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
      start_packet    <= 1'b0;
      error_bad_frame <= 1'b0;
      error_bad_fcs   <= 1'b0;
      error_runt      <= 1'b0;
      error_oversize  <= 1'b0;
    end else begin
      m_axis_tdata    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
      start_packet    <= is_start;
      error_bad_frame <= is_bad;
      error_bad_fcs   <= is_fcs;
      error_runt      <= is_runt;
      error_oversize  <= end_over;
      if (clk_enable) begin
        unique case (state)
          IDLE: begin
            crc <= '1;
            if (sfd_hit) begin
              state <= PAYLOAD;
              len   <= gmii_rx_dv ? CW'(5) : CW'(4);
            end
          end
          PAYLOAD: begin
            crc           <= crc_next;
            m_axis_tdata  <= rxd_d[4];
            m_axis_tvalid <= 1'b1;
            if (end_er || end_norm || end_over) begin
              m_axis_tlast    <= 1'b1;
              m_axis_tuser    <= is_bad;
              frame_len       <= len_sat;
              frame_len_valid <= 1'b1;
            end
            if (end_er || end_over) begin
              state <= WAIT_LAST;
            end else if (end_norm) begin
              state <= IDLE;
            end else begin
              len <= len + CW'(1);
            end
          end
          WAIT_LAST: begin
            if (!gmii_rx_dv) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // saturating statistics; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_good     <= '0;
      stat_bad      <= '0;
      stat_fcs      <= '0;
      stat_runt     <= '0;
      stat_oversize <= '0;
    end else begin
      stat_good     <= sat_inc(stat_good, is_good);
      stat_bad      <= sat_inc(stat_bad, is_bad);
      stat_fcs      <= sat_inc(stat_fcs, is_fcs);
      stat_runt     <= sat_inc(stat_runt, is_runt);
      stat_oversize <= sat_inc(stat_oversize, end_over);
    end
  end

endmodule
